// File: rtl/rob_commit_queue.sv
// Circular reorder buffer: hands out rename tags at dispatch, captures CDB results,
// retires in program order and pulses flush for one cycle after a mispredicted retire.
module rob_commit_queue #(
  parameter int DEPTH = 32,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_rd,
  output logic             dispatch_ready,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_v,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [PTR_W-1:0] count,
  output logic             empty
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] mispred;
  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      val_q [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             flush_q;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  logic             dispatch_fire;
  logic             cdb_fire;
  logic             mispred_retire;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];

  // Full when indices match but the wrap bits differ; empty when pointers match exactly.
  assign full  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign empty = (head == tail);
  assign count = tail - head;
  assign flush = flush_q;

  assign dispatch_ready = !full && !flush_q;
  assign dispatch_tag   = tail_idx;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  assign cdb_fire = cdb_valid && busy[cdb_tag] && !flush_q;

  // Commit reads the head straight from storage; a same-cycle CDB result is not bypassed.
  assign commit_valid   = busy[head_idx] && done[head_idx] && !flush_q;
  assign commit_rd      = busy[head_idx] ? rd_q[head_idx]  : 5'd0;
  assign commit_v       = busy[head_idx] ? val_q[head_idx] : 32'd0;
  assign commit_tag     = head_idx;
  assign commit_we      = commit_valid && (commit_rd != 5'd0);
  assign mispred_retire = commit_valid && mispred[head_idx];

  // Control state: pointers, per-entry status bits and the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      busy    <= '0;
      done    <= '0;
      mispred <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= mispred_retire;
      if (mispred_retire) begin
        // The mispredicted branch retires this cycle; everything younger is discarded.
        head    <= '0;
        tail    <= '0;
        busy    <= '0;
        done    <= '0;
        mispred <= '0;
      end else begin
        if (dispatch_fire) begin
          busy[tail_idx]    <= 1'b1;
          done[tail_idx]    <= 1'b0;
          mispred[tail_idx] <= 1'b0;
          tail              <= tail + PTR_W'(1);
        end
        if (cdb_fire) begin
          done[cdb_tag]    <= 1'b1;
          mispred[cdb_tag] <= cdb_mispredict;
        end
        if (commit_valid) begin
          busy[head_idx] <= 1'b0;
          head           <= head + PTR_W'(1);
        end
      end
    end
  end

  // Payload storage: only ever read through a busy entry, so it needs no reset.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      rd_q[tail_idx] <= dispatch_rd;
    end
    if (cdb_fire) begin
      val_q[cdb_tag] <= cdb_value;
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Bench for rob_commit_queue: hand-derived vector table, directed corner sequences,
// and a reference model with an in-order retire scoreboard running every cycle.
module tb_rob_commit_queue;
  localparam int DEPTH = 32;
  localparam int TAG_W = 5;
  localparam int PTR_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch_valid;
  logic [4:0]       dispatch_rd;
  logic             dispatch_ready;
  logic [TAG_W-1:0] dispatch_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             cdb_mispredict;
  logic             commit_valid;
  logic             commit_we;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_v;
  logic [TAG_W-1:0] commit_tag;
  logic             flush;
  logic [PTR_W-1:0] count;
  logic             empty;

  always #5 clk = ~clk;

  rob_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
    .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_v(commit_v), .commit_tag(commit_tag),
    .flush(flush), .count(count), .empty(empty)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [4:0] rd; logic [TAG_W-1:0] tag; } sb_t;
  sb_t sb_q[$];

  bit          m_busy [DEPTH];
  bit          m_done [DEPTH];
  bit          m_mis  [DEPTH];
  logic [31:0] m_val  [DEPTH];
  int          m_head, m_tail, m_count;
  bit          m_flush;

  typedef struct {
    bit r; bit dv; logic [4:0] drd;
    bit cv; logic [4:0] ctag; logic [31:0] cval; bit cmis;
    bit e_rdy; logic [4:0] e_tag; int e_cnt; bit e_cv; bit e_we; logic [4:0] e_rd; logic [31:0] e_v;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_mis[i] = 1'b0; m_val[i] = 32'd0;
    end
    m_head = 0; m_tail = 0; m_count = 0; m_flush = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, compare outputs against the model, take the edge, update the model.
  task automatic cycle(input bit r, input bit dv, input logic [4:0] drd, input bit cv,
                       input logic [TAG_W-1:0] ctag, input logic [31:0] cval, input bit cmis);
    bit  exp_cv, exp_rdy, cdb_ok, new_flush;
    sb_t s;
    rst = r; dispatch_valid = dv; dispatch_rd = drd;
    cdb_valid = cv; cdb_tag = ctag; cdb_value = cval; cdb_mispredict = cmis;
    #2;
    exp_cv  = m_busy[m_head] && m_done[m_head] && !m_flush;
    exp_rdy = (m_count < DEPTH) && !m_flush;
    chk("dispatch_ready", 32'(dispatch_ready), 32'(exp_rdy));
    chk("dispatch_tag", 32'(dispatch_tag), 32'(m_tail));
    chk("count", 32'(count), 32'(m_count));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
    if (exp_cv) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: commit expected with empty scoreboard at %0t", $time);
      end else begin
        s = sb_q.pop_front();
        chk("commit_rd", 32'(commit_rd), 32'(s.rd));
        chk("commit_tag", 32'(commit_tag), 32'(s.tag));
        chk("commit_v", commit_v, m_val[s.tag]);
        chk("commit_we", 32'(commit_we), 32'(s.rd != 5'd0));
      end
    end else begin
      chk("commit_we_idle", 32'(commit_we), 32'd0);
    end
    cdb_ok    = cv && m_busy[ctag] && !m_flush;
    new_flush = exp_cv && m_mis[m_head];
    @(posedge clk); #1;
    if (r) begin
      model_reset();
    end else if (new_flush) begin
      model_reset();
      m_flush = 1'b1;
    end else begin
      m_flush = 1'b0;
      if (dv && exp_rdy) begin
        m_busy[m_tail] = 1'b1; m_done[m_tail] = 1'b0; m_mis[m_tail] = 1'b0;
        sb_q.push_back('{rd: drd, tag: TAG_W'(m_tail)});
        m_tail = (m_tail + 1) % DEPTH;
        m_count++;
      end
      if (cdb_ok) begin
        m_done[ctag] = 1'b1; m_val[ctag] = cval; m_mis[ctag] = cmis;
      end
      if (exp_cv) begin
        m_busy[m_head] = 1'b0;
        m_head = (m_head + 1) % DEPTH;
        m_count--;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  logic [TAG_W-1:0] prev_tag;

  initial begin
    // Expected outputs observed in the cycle the inputs are applied, before the edge.
    //         r  dv drd   cv ctag cval      mis  rdy tag cnt cv we rd   v
    vt[0]  = '{0, 1, 5'd5, 0, 5'd0, 32'h0,   0,   1, 5'd0, 0, 0, 0, 5'd0, 32'h0};
    vt[1]  = '{0, 1, 5'd6, 0, 5'd0, 32'h0,   0,   1, 5'd1, 1, 0, 0, 5'd0, 32'h0};
    vt[2]  = '{0, 0, 5'd0, 1, 5'd1, 32'h22,  0,   1, 5'd2, 2, 0, 0, 5'd0, 32'h0};
    vt[3]  = '{0, 0, 5'd0, 1, 5'd0, 32'h11,  0,   1, 5'd2, 2, 0, 0, 5'd0, 32'h0};
    vt[4]  = '{0, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd2, 2, 1, 1, 5'd5, 32'h11};
    vt[5]  = '{0, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd2, 1, 1, 1, 5'd6, 32'h22};
    vt[6]  = '{0, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd2, 0, 0, 0, 5'd0, 32'h0};
    vt[7]  = '{1, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd2, 0, 0, 0, 5'd0, 32'h0};
    vt[8]  = '{0, 1, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd0, 0, 0, 0, 5'd0, 32'h0};
    vt[9]  = '{0, 0, 5'd0, 1, 5'd0, 32'h33,  0,   1, 5'd1, 1, 0, 0, 5'd0, 32'h0};
    vt[10] = '{0, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd1, 1, 1, 0, 5'd0, 32'h33};
    vt[11] = '{0, 0, 5'd0, 1, 5'd5, 32'h99,  0,   1, 5'd1, 0, 0, 0, 5'd0, 32'h0};
    vt[12] = '{0, 0, 5'd0, 0, 5'd0, 32'h0,   0,   1, 5'd1, 0, 0, 0, 5'd0, 32'h0};

    rst = 1'b1; dispatch_valid = 1'b0; dispatch_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_we", 32'(commit_we), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_v", commit_v, 32'd0);
    chk("rst_commit_tag", 32'(commit_tag), 32'd0);

    // Basic allocate, out-of-order completion, in-order retire, rd=0 commit, stale CDB.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d_ready", i), 32'(dispatch_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_tag", i), 32'(dispatch_tag), 32'(vt[i].e_tag));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_cvalid", i), 32'(commit_valid), 32'(vt[i].e_cv));
      chk($sformatf("vec%0d_we", i), 32'(commit_we), 32'(vt[i].e_we));
      if (vt[i].e_cv) begin
        chk($sformatf("vec%0d_rd", i), 32'(commit_rd), 32'(vt[i].e_rd));
        chk($sformatf("vec%0d_v", i), commit_v, vt[i].e_v);
      end
      cycle(vt[i].r, vt[i].dv, vt[i].drd, vt[i].cv, vt[i].ctag, vt[i].cval, vt[i].cmis);
    end

    // Fill to capacity; a commit in the full cycle must not let a dispatch through.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 1'b0);
    chk("full_count", 32'(count), 32'd32);
    chk("full_ready", 32'(dispatch_ready), 32'd0);
    cycle(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("full_tail_kept", 32'(dispatch_tag), 32'd0);
    chk("full_count_kept", 32'(count), 32'd32);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hAB, 1'b0);
    chk("full_commit_valid", 32'(commit_valid), 32'd1);
    cycle(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("after_commit_ready", 32'(dispatch_ready), 32'd1);
    chk("after_commit_count", 32'(count), 32'd31);
    cycle(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("refill_count", 32'(count), 32'd32);

    // Mispredicted head: retires with its write, then one flush cycle, younger work discarded.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 5'(i + 1), 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 1; i < 4; i++) cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'(i), 32'(i * 16), 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h55, 1'b1);
    chk("mis_commit_valid", 32'(commit_valid), 32'd1);
    chk("mis_commit_we", 32'(commit_we), 32'd1);
    chk("mis_commit_tag", 32'(commit_tag), 32'd0);
    cycle(1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("mis_flush", 32'(flush), 32'd1);
    chk("mis_flush_ready", 32'(dispatch_ready), 32'd0);
    chk("mis_flush_cvalid", 32'(commit_valid), 32'd0);
    cycle(1'b0, 1'b1, 5'd8, 1'b1, 5'd1, 32'h77, 1'b0);
    chk("post_flush", 32'(flush), 32'd0);
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_tag", 32'(dispatch_tag), 32'd0);
    repeat (3) idle();

    // Streaming across the pointer wrap.
    do_reset();
    prev_tag = '0;
    for (int i = 0; i < 40; i++) begin
      if (i == 31) chk("wrap_tag31", 32'(dispatch_tag), 32'd31);
      if (i == 32) chk("wrap_tag0", 32'(dispatch_tag), 32'd0);
      chk("stream_count_bound", 32'(count <= PTR_W'(DEPTH)), 32'd1);
      cycle(1'b0, 1'b1, 5'(i % 31 + 1), i > 0, prev_tag, 32'(i * 3 + 1), 1'b0);
      prev_tag = 5'(i % DEPTH);
    end
    repeat (4) idle();

    // Randomised traffic, including stray CDB writes and occasional mispredicts.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) < 7, 5'((m_head + int'($urandom_range(0, 3))) % DEPTH),
            $urandom, $urandom_range(0, 29) == 0);
    end

    // Reset landing in the middle of a flush.
    do_reset();
    cycle(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h66, 1'b1);
    idle();
    chk("rstflush_flush_hi", 32'(flush), 32'd1);
    do_reset();
    chk("rstflush_flush", 32'(flush), 32'd0);
    chk("rstflush_empty", 32'(empty), 32'd1);
    chk("rstflush_ready", 32'(dispatch_ready), 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit_queue.md
Name: rob_commit_queue

Overview:
Circular reorder buffer that allocates rename tags at dispatch, collects results from the common data bus (CDB), and retires entries in program order. It is the producer side of the register file's rename/commit interface. On dispatch it supplies the tag written into a register's rob_num. On retire it drives the commit write (we, rd, value, tag) and the one-cycle flush that clears all rename state after a mispredicted branch.

Parameters:
DEPTH, 32, number of entries (power of 2, >=4)
TAG_W, $clog2(DEPTH), tag width; index into entry array
PTR_W, $clog2(DEPTH)+1, head/tail pointer width; MSB is the wrap bit

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
dispatch_valid  in  1  decode presents an instruction to allocate
dispatch_rd  in  5  architectural destination; 0 = no register write
dispatch_ready  out  1  entry available this cycle (not full, not flushing)
dispatch_tag  out  TAG_W  tag that will be allocated (tail index); valid whenever dispatch_ready=1
cdb_valid  in  1  execution result broadcast
cdb_tag  in  TAG_W  entry the result belongs to
cdb_value  in  32  result value
cdb_mispredict  in  1  entry is a branch that resolved mispredicted
commit_valid  out  1  head entry retires this cycle
commit_we  out  1  commit_valid && head rd != 0
commit_rd  out  5  head destination register
commit_v  out  32  head result value
commit_tag  out  TAG_W  head tag, compared by the register file against rob_num
flush  out  1  one-cycle pulse clearing all rename state
count  out  PTR_W  occupied entries, 0..DEPTH
empty  out  1  count==0

Behaviour:
- Entry fields: busy, done, mispred, rd[4:0], val[31:0].
- head and tail are PTR_W bits wide.
- empty: head==tail. full: indices equal and wrap bits differ.
- Reset: head=tail=0, all busy/done/mispred=0, flush=0, count=0, empty=1. All commit_* outputs are 0 (combinational from a non-busy head).
- dispatch_ready = !full && !flush. dispatch_tag = tail[TAG_W-1:0], combinational.
- Dispatch fires on dispatch_valid && dispatch_ready. At the clock edge: entry[tail] gets busy=1, done=0, mispred=0, rd=dispatch_rd; tail increments, wrapping by natural overflow.
- Full blocks dispatch even if a commit occurs in the same cycle. There is no same-cycle slot reuse.
- CDB write: when cdb_valid && entry[cdb_tag].busy && !flush, set done=1, val=cdb_value, mispred=cdb_mispredict at the edge.
  - A CDB write to a non-busy entry is ignored.
  - A CDB write to the head takes effect next cycle; commit has no bypass from the CDB.
- Commit is combinational from the head entry:
  - commit_valid = entry[head].busy && entry[head].done && !flush.
  - commit_rd, commit_v and commit_tag come from the head entry.
  - At most one retire per cycle. On retire: clear entry[head].busy and increment head at the edge.
- Misprediction, two-cycle sequence:
  - Cycle N: the mispredicted head retires normally, so its rd write reaches the register file before rename state is cleared.
  - Edge ending N: all entries are cleared (busy/done/mispred=0), head=tail=0, flush<=1. Any dispatch in cycle N is discarded.
  - Cycle N+1: flush=1, dispatch_ready=0, CDB writes ignored, commit_valid=0.
  - Edge ending N+1: flush<=0.
- A dispatch and a commit in the same cycle leave count unchanged.
- The queue drains correctly across the pointer wrap (index DEPTH-1 → 0).
- rst has priority over every other event, including the middle of a flush.

Test Plan:
1. Reset, then dispatch rd=5, rd=6 → dispatch_tag 0 then 1; count=2; commit_valid=0.
2. CDB tag1 val=0x22, next cycle CDB tag0 val=0x11 → commit_valid only after tag0 is done. Commits retire in order: (rd5, 0x11, tag0) then (rd6, 0x22, tag1); empty=1 afterwards.
3. Dispatch 32 entries with no completions → dispatch_ready=0, count=32. A 33rd dispatch_valid is ignored and tail is unchanged. One commit then re-enables dispatch.
4. Dispatch rd=0 (tag0), complete it → commit_valid=1, commit_we=0.
5. Dispatch tags 0..3; CDB tag0 with mispredict=1, plus CDB for tags 1..3 → tag0 commits with commit_we=1. Next cycle flush=1 and dispatch_ready=0; then count=0 and the next dispatch_tag=0. Tags 1..3 never commit.
6. Stream 40 dispatch/complete/commit pairs → tags wrap 31→0; count never exceeds 32. rst asserted during the flush cycle → flush=0 and empty=1 the next cycle.
